fp_alu_select_pipe: RTL

Parametrised successor to the fixed 4-deep accumulator-operand select stage. Delays operand pairs A/B through a PIPE_DEPTH-deep elastic pipeline. At the tail it joins each pair with a late-arriving control beat (op, select_data, exponent_big_a) and registers the chosen operand. Sits between the FP exponent-compare logic and the accumulator ALU. Adds valid/ready flow control, bubble collapse and a 2-bit op mode.

---
 rtl/fp_alu_select_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fp_alu_select_pipe.sv
// Elastic operand delay line with late control join and registered operand select.
// Optional B-select counter enabled by defining FP_ALU_SELECT_CNT_EN.
module fp_alu_select_pipe #(
    parameter int ACCUM_DATA_WIDTH = 32,
    parameter int PIPE_DEPTH       = 4,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic signed [ACCUM_DATA_WIDTH-1:0] alu_data_a_i,
    input  logic signed [ACCUM_DATA_WIDTH-1:0] alu_data_b_i,
    input  logic                               ctrl_valid_i,
    output logic                               ctrl_ready_o,
    input  logic [1:0]                         alu_op,
    input  logic                               select_data,
    input  logic                               i_exponent_big_a,
    output logic                               valid_o,
    input  logic                               ready_i,
`ifdef FP_ALU_SELECT_CNT_EN
    output logic [CNT_WIDTH-1:0]               sel_b_cnt_o,
    input  logic                               cnt_clr_i,
`endif
    output logic signed [ACCUM_DATA_WIDTH-1:0] alu_data_o
);

    localparam int LAST = PIPE_DEPTH - 1;

    logic [PIPE_DEPTH-1:0]               vld;
    logic signed [ACCUM_DATA_WIDTH-1:0]  a_q [PIPE_DEPTH];
    logic signed [ACCUM_DATA_WIDTH-1:0]  b_q [PIPE_DEPTH];

    logic [PIPE_DEPTH-1:0]               stage_rdy;
    logic [PIPE_DEPTH-1:0]               in_vld;
    logic signed [ACCUM_DATA_WIDTH-1:0]  in_a [PIPE_DEPTH];
    logic signed [ACCUM_DATA_WIDTH-1:0]  in_b [PIPE_DEPTH];

    logic                                out_free;
    logic                                fire;
    logic signed [ACCUM_DATA_WIDTH-1:0]  sel;
    logic                                sel_is_b;

    assign out_free     = ~valid_o | ready_i;
    assign ctrl_ready_o = vld[LAST] & out_free;
    assign fire         = ctrl_ready_o & ctrl_valid_i;
    assign ready_o      = stage_rdy[0];

    // A stage is ready when it, or any stage below it, has a bubble, or the tail fires.
    // Folding the chain through a local keeps the ready path free of vector self-reads.
    always_comb begin
        logic rdy_chain;
        stage_rdy = '0;
        rdy_chain = fire;
        for (int k = LAST; k >= 0; k--) begin
            rdy_chain    = ~vld[k] | rdy_chain;
            stage_rdy[k] = rdy_chain;
        end
    end

    always_comb begin
        in_vld    = '0;
        in_vld[0] = valid_i;
        in_a[0]   = alu_data_a_i;
        in_b[0]   = alu_data_b_i;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            in_vld[k] = vld[k-1];
            in_a[k]   = a_q[k-1];
            in_b[k]   = b_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (stage_rdy[k]) begin
                    vld[k] <= in_vld[k];
                    if (in_vld[k]) begin
                        a_q[k] <= in_a[k];
                        b_q[k] <= in_b[k];
                    end
                end
            end
        end
    end

    always_comb begin
        sel      = a_q[LAST];
        sel_is_b = 1'b0;
        unique case (alu_op)
            2'b00: sel = a_q[LAST];
            2'b01: begin
                if (select_data ^ i_exponent_big_a) begin
                    sel = a_q[LAST];
                end else begin
                    sel      = b_q[LAST];
                    sel_is_b = 1'b1;
                end
            end
            2'b10: begin
                sel      = b_q[LAST];
                sel_is_b = 1'b1;
            end
            default: sel = a_q[LAST];
        endcase
    end

    // Discard (op 11) consumes the pair but only clears valid_o, which is free by then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            alu_data_o <= '0;
        end else if (fire && (alu_op != 2'b11)) begin
            valid_o    <= 1'b1;
            alu_data_o <= sel;
        end else if (out_free) begin
            valid_o <= 1'b0;
        end
    end

`ifdef FP_ALU_SELECT_CNT_EN
    logic [CNT_WIDTH-1:0] sel_b_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_b_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            sel_b_cnt_q <= '0;
        end else if (fire && sel_is_b && (sel_b_cnt_q != '1)) begin
            sel_b_cnt_q <= sel_b_cnt_q + 1'b1;
        end
    end

    assign sel_b_cnt_o = sel_b_cnt_q;
`else
    localparam int unused_cnt_width = CNT_WIDTH;
    logic unused_sel_is_b;
    assign unused_sel_is_b = sel_is_b;
`endif

endmodule
